// File: rtl/draw_line_stream.sv
// Bresenham line rasteriser: takes two endpoints and streams one pixel per
// valid/ready handshake, then pulses FINISH once at the end of the line.
module draw_line_stream #(
  parameter int COORD_W = 8
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               START,
  input  logic [COORD_W-1:0] X_1,
  input  logic [COORD_W-1:0] Y_1,
  input  logic [COORD_W-1:0] X_2,
  input  logic [COORD_W-1:0] Y_2,
  input  logic               ABORT,
  input  logic               PIX_READY,
  output logic               PIX_VALID,
  output logic [COORD_W-1:0] X_Out,
  output logic [COORD_W-1:0] Y_Out,
  output logic               BUSY,
  output logic               FINISH,
  output logic [1:0]         dbg_state
);

  // Pixel stream: a pixel transfers on any rising edge with PIX_VALID and
  // PIX_READY both high; once raised, PIX_VALID and X_Out/Y_Out hold until
  // that transfer happens (only ABORT or reset may withdraw a pixel).

  localparam int EW = COORD_W + 2;
  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic sx_neg_q, sy_neg_q;

  logic [COORD_W-1:0]   adx, ady;
  logic signed [EW-1:0] dx_init, dy_init;
  logic signed [EW:0]   e2, dx_ext, dy_ext;
  logic signed [EW-1:0] err_add_x, err_add_y, err_step;
  logic step_x, step_y, at_end;

  always_comb begin
    adx       = (x2_q >= x1_q) ? (x2_q - x1_q) : (x1_q - x2_q);
    ady       = (y2_q >= y1_q) ? (y2_q - y1_q) : (y1_q - y2_q);
    dx_init   = signed'({2'b00, adx});
    dy_init   = -signed'({2'b00, ady});
    e2        = {err_q, 1'b0};
    dx_ext    = {dx_q[EW-1], dx_q};
    dy_ext    = {dy_q[EW-1], dy_q};
    step_x    = (e2 >= dy_ext);
    step_y    = (e2 <= dx_ext);
    // Both corrections are taken from the same pre-update error term.
    err_add_x = step_x ? dy_q : '0;
    err_add_y = step_y ? dx_q : '0;
    err_step  = err_q + err_add_x + err_add_y;
    at_end    = (x_q == x2_q) && (y_q == y2_q);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (START) state_nxt = SETUP;
      SETUP: state_nxt = ABORT ? DONE : DRAW;
      DRAW:  if (ABORT || (PIX_READY && at_end)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      if (state == IDLE && START) begin
        x1_q <= X_1;
        y1_q <= Y_1;
        x2_q <= X_2;
        y2_q <= Y_2;
      end
      if (state == SETUP) begin
        dx_q     <= dx_init;
        dy_q     <= dy_init;
        err_q    <= dx_init + dy_init;
        sx_neg_q <= !(x1_q < x2_q);
        sy_neg_q <= !(y1_q < y2_q);
        x_q      <= x1_q;
        y_q      <= y1_q;
      end
      // The walk halts on the endpoint, so a step can never wrap the range.
      if (state == DRAW && PIX_READY && !at_end && !ABORT) begin
        err_q <= err_step;
        if (step_x) x_q <= sx_neg_q ? (x_q - C_ONE) : (x_q + C_ONE);
        if (step_y) y_q <= sy_neg_q ? (y_q - C_ONE) : (y_q + C_ONE);
      end
    end
  end

  assign PIX_VALID = (state == DRAW);
  assign BUSY      = (state != IDLE);
  assign FINISH    = (state == DONE);
  assign X_Out     = x_q;
  assign Y_Out     = y_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_draw_line_stream.sv
// Bench for draw_line_stream: hand-derived pixel sequences go into a queue
// and are popped as the DUT hands pixels over.
module tb_draw_line_stream;

  localparam int W = 8;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic         START = 1'b0;
  logic         ABORT = 1'b0;
  logic         PIX_READY = 1'b1;
  logic [W-1:0] X_1 = '0, Y_1 = '0, X_2 = '0, Y_2 = '0;
  logic         PIX_VALID, BUSY, FINISH;
  logic [W-1:0] X_Out, Y_Out;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int hs_count = 0;
  int fin_count = 0;
  int fin_cyc = 0;
  int hs_cyc[$];
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_px;
  logic           stall_prev = 1'b0;
  logic [W-1:0]   held_x = '0, held_y = '0;

  draw_line_stream #(.COORD_W(W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .START(START),
    .X_1(X_1), .Y_1(Y_1), .X_2(X_2), .Y_2(Y_2),
    .ABORT(ABORT), .PIX_READY(PIX_READY), .PIX_VALID(PIX_VALID),
    .X_Out(X_Out), .Y_Out(Y_Out), .BUSY(BUSY), .FINISH(FINISH),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // scoreboard monitor, sampling on the falling edge
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1) begin
      if (stall_prev) begin
        checks++;
        if (PIX_VALID !== 1'b1 || X_Out !== held_x || Y_Out !== held_y) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b (%0d,%0d) expected v=1 (%0d,%0d)",
                   PIX_VALID, X_Out, Y_Out, held_x, held_y);
        end
      end
      if (PIX_VALID === 1'b1 && PIX_READY === 1'b1) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", X_Out, Y_Out);
        end else begin
          exp_px = exp_q.pop_front();
          if ({X_Out, Y_Out} !== exp_px) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d) expected (%0d,%0d)",
                     X_Out, Y_Out, exp_px[2*W-1:W], exp_px[W-1:0]);
          end
        end
      end
      if (FINISH === 1'b1) begin
        fin_count++;
        fin_cyc = cyc;
      end
      stall_prev = (PIX_VALID === 1'b1) && (PIX_READY === 1'b0) && (ABORT === 1'b0);
      held_x = X_Out;
      held_y = Y_Out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // driver tasks
  task automatic push_px(input int x, input int y);
    exp_q.push_back({W'(x), W'(y)});
  endtask

  task automatic start_line(input int a, input int b, input int c, input int d);
    @(posedge ACLK); #1;
    X_1 = W'(a); Y_1 = W'(b); X_2 = W'(c); Y_2 = W'(d);
    START = 1'b1;
    s_cyc = cyc;
    @(posedge ACLK); #1;
    START = 1'b0;
    X_1 = W'($urandom_range(0, 255)); Y_1 = W'($urandom_range(0, 255));
    X_2 = W'($urandom_range(0, 255)); Y_2 = W'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input string name, input bit bp);
    int  f0 = fin_count;
    bit  ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge ACLK); #1;
      if (fin_count > f0) begin
        ok = 1'b1;
        break;
      end
      if (bp) begin
        PIX_READY = (i % 3 == 0);
        START = (i == 2);
        if (i == 2) begin
          X_1 = 8'd20; Y_1 = 8'd20; X_2 = 8'd30; Y_2 = 8'd40;
        end
      end
    end
    PIX_READY = 1'b1;
    START = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got no FINISH expected FINISH within 200 cycles", name);
    end
    checks++;
    if (BUSY !== 1'b0 || FINISH !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_finish: got busy=%0b finish=%0b expected 0 0", name, BUSY, FINISH);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pixels: got %0d left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if (fin_count != f0 + 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_finish_count: got finishes=%0d busy=%0b expected 1 0", name, fin_count - f0, BUSY);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    #3;
    checks++;
    if (PIX_VALID !== 1'b0 || BUSY !== 1'b0 || FINISH !== 1'b0 ||
        X_Out !== '0 || Y_Out !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%0b b=%0b f=%0b x=%0d y=%0d st=%0d expected all 0",
               PIX_VALID, BUSY, FINISH, X_Out, Y_Out, dbg_state);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);
  endtask

  task automatic test_horizontal();
    hs_cyc.delete();
    push_px(0, 0); push_px(1, 0); push_px(2, 0); push_px(3, 0);
    start_line(0, 0, 3, 0);
    wait_done("horizontal", 1'b0);
    checks++;
    if (hs_cyc.size() != 4) begin
      errors++;
      $display("FAIL horiz_count: got %0d expected 4", hs_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (hs_cyc[k] != s_cyc + 2 + k) begin
          errors++;
          $display("FAIL horiz_timing%0d: got cycle %0d expected %0d", k, hs_cyc[k], s_cyc + 2 + k);
        end
      end
      checks++;
      if (fin_cyc != hs_cyc[3] + 1) begin
        errors++;
        $display("FAIL horiz_finish_cycle: got %0d expected %0d", fin_cyc, hs_cyc[3] + 1);
      end
    end
  endtask

  task automatic test_steep();
    push_px(2, 1); push_px(3, 2); push_px(3, 3); push_px(4, 4); push_px(4, 5);
    start_line(2, 1, 4, 5);
    wait_done("steep", 1'b0);
  endtask

  task automatic test_reverse_edge();
    push_px(255, 255); push_px(254, 255); push_px(253, 255);
    start_line(255, 255, 253, 255);
    wait_done("reverse", 1'b0);
    push_px(7, 7);
    start_line(7, 7, 7, 7);
    wait_done("point", 1'b0);
  endtask

  task automatic test_back_pressure();
    push_px(0, 0); push_px(1, 0); push_px(2, 1); push_px(3, 1); push_px(4, 2); push_px(5, 2);
    start_line(0, 0, 5, 2);
    wait_done("backpressure", 1'b1);
  endtask

  task automatic test_abort();
    int h0 = hs_count;
    int f0 = fin_count;
    bit ok = 1'b0;
    push_px(0, 0); push_px(1, 1);
    start_line(0, 0, 9, 9);
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK); #1;
      if (hs_count >= h0 + 2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_wait: got %0d pixels expected 2", hs_count - h0);
    end
    PIX_READY = 1'b0;
    ABORT = 1'b1;
    @(posedge ACLK); #1;
    ABORT = 1'b0;
    PIX_READY = 1'b1;
    checks++;
    if (PIX_VALID !== 1'b0 || FINISH !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: got v=%0b f=%0b b=%0b expected 0 1 1", PIX_VALID, FINISH, BUSY);
    end
    @(posedge ACLK); #1;
    checks++;
    if (BUSY !== 1'b0 || FINISH !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL abort_idle: got b=%0b f=%0b st=%0d expected 0 0 0", BUSY, FINISH, dbg_state);
    end
    checks++;
    if (fin_count != f0 + 1 || hs_count != h0 + 2) begin
      errors++;
      $display("FAIL abort_counts: got fin=%0d pix=%0d expected 1 2", fin_count - f0, hs_count - h0);
    end
    push_px(1, 2); push_px(2, 2); push_px(3, 2);
    start_line(1, 2, 3, 2);
    wait_done("after_abort", 1'b0);
  endtask

  task automatic test_reset_mid_line();
    int h0 = hs_count;
    int f0;
    int h1;
    bit ok = 1'b0;
    for (int k = 0; k < 10; k++) push_px(k, k);
    start_line(0, 0, 9, 9);
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK); #1;
      if (hs_count >= h0 + 3) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_wait: got %0d pixels expected 3", hs_count - h0);
    end
    #1;
    ARESETn = 1'b0;
    #1;
    checks++;
    if (PIX_VALID !== 1'b0 || BUSY !== 1'b0 || FINISH !== 1'b0 || X_Out !== '0 || Y_Out !== '0) begin
      errors++;
      $display("FAIL rst_async: got v=%0b b=%0b f=%0b x=%0d y=%0d expected all 0",
               PIX_VALID, BUSY, FINISH, X_Out, Y_Out);
    end
    exp_q.delete();
    f0 = fin_count;
    h1 = hs_count;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    repeat (5) @(posedge ACLK);
    #1;
    checks++;
    if (fin_count != f0 || hs_count != h1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: got fin=%0d pix=%0d busy=%0b expected 0 0 0",
               fin_count - f0, hs_count - h1, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_reverse_edge();
    test_back_pressure();
    test_abort();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
